// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory.
package mem_pkg;

  localparam int WORD_SIZE = 16;
  localparam int CNT_W     = 4;
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write port, combinational read port.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Single write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/wait_state_memory.sv
// Unified memory with a fixed number of wait cycles per access.
// Optional feature: MEM_BOUNDS_CHECK_EN -- out-of-range accesses are
// suppressed (writes dropped, reads return 0) and flagged on addr_err.
module wait_state_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m,
  input  logic                 write_m,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 mem_ready,
  output logic                 addr_err
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $fatal(1, "wait_state_memory: LATENCY %0d outside %0d..%0d", LATENCY, LAT_MIN, LAT_MAX);
  end

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [ADDR_W-1:0]  laddr, laddr_nx;
  logic               lwr, lwr_nx;     // latched op: 1 = write
  logic               loob, loob_nx;   // latched out-of-range flag
  logic               we;
  logic               acc_oob;
  logic               held;
  logic [WORD_SIZE-1:0] rdata, rd_word;

`ifdef MEM_BOUNDS_CHECK_EN
  assign acc_oob = (address >> ADDR_W) != '0;
`else
  // Upper address bits alias into the array.
  logic unused_addr_hi;
  assign unused_addr_hi = |(address >> ADDR_W);
  assign acc_oob        = 1'b0;
`endif

  // Only the op being served keeps the access alive.
  assign held = lwr ? write_m : read_m;

  // Next-state: accept from IDLE, or straight out of DONE when a new request is already up.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    laddr_nx = laddr;
    lwr_nx   = lwr;
    loob_nx  = loob;
    we       = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (write_m || read_m) begin
          state_nx = WAIT;
          laddr_nx = address[ADDR_W-1:0];
          lwr_nx   = write_m;
          loob_nx  = acc_oob;
          cnt_nx   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (!held) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx = DONE;
          we       = lwr && !loob;   // commit on the DONE entry edge
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM and latched request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      laddr <= '0;
      lwr   <= 1'b0;
      loob  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      laddr <= laddr_nx;
      lwr   <= lwr_nx;
      loob  <= loob_nx;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  // Sticky error, set when an out-of-range access reaches DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       addr_err <= 1'b0;
    else if (state == WAIT && state_nx == DONE && loob) addr_err <= 1'b1;
  end
`else
  assign addr_err = 1'b0;
`endif

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(WORD_SIZE)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (laddr),
    .wdata (data),
    .raddr (laddr),
    .rdata (rdata)
  );

  assign mem_ready = (state == DONE);
  assign rd_word   = loob ? '0 : rdata;
  // Bus is driven only for a read in DONE; reset releases it via the state flop.
  assign data      = (state == DONE && !lwr) ? rd_word : 'z;

endmodule
